text_term_ctrl: RTL and testbench
=================================

Name: text_term_ctrl

Overview:
Terminal write controller between the scan-code-to-ASCII lookup and the character text RAM that the VGA character generator reads. It accepts one ASCII code per handshake and tracks a cursor on a COLS x ROWS grid. It handles printable characters, newline and backspace, and scrolls through a circular top-row pointer with hardware clearing of the recycled row. It produces single-cell write strobes and the top_row offset the display read path needs.

Parameters:
COLS, 70, characters per row
ROWS, 30, character rows
ADDR_W, 12, text RAM address width; ROWS*COLS must be at most 2^ADDR_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
key_valid  in  1  one-cycle strobe: key_asc is valid
key_asc  in  8  ASCII code
ready  out  1  high only in IDLE; key_valid is accepted only when ready=1
ovf  out  1  one-cycle pulse when key_valid arrives while ready=0 (key dropped)
wr_en  out  1  text RAM write strobe, one cell per cycle
wr_addr  out  ADDR_W  physical cell address
wr_data  out  8  character to write
cur_row  out  5  logical cursor row, 0..ROWS-1
cur_col  out  7  cursor column, 0..COLS-1
top_row  out  5  physical row currently displayed as logical row 0

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- All outputs are registered.
- Physical address: phys_row = (cur_row + top_row) mod ROWS; wr_addr = phys_row*COLS + col. Mod is compare-and-subtract; no divider.
- States: INIT, IDLE, PUT, SCROLL_CLR.
- Reset values: state=INIT; ready=0, ovf=0, wr_en=0, wr_addr=0, wr_data=0, cur_row=0, cur_col=0, top_row=0.
- INIT:
  - Writes 0x20 to addresses 0..ROWS*COLS-1, one per cycle, ascending.
  - The first write occurs in the first cycle after rst deasserts.
  - After the last write, go to IDLE; ready=1 the following cycle.
- IDLE, when key_valid=1:
  - The code is latched and the FSM moves to PUT.
  - ready drops the next cycle.
  - Any resulting write appears on wr_en exactly 1 cycle after acceptance.
- PUT, by code:
  - 0x20..0x7E: write the code at the cursor, then advance. If cur_col<COLS-1, col+1. Otherwise do a newline.
  - 0x0D or 0x0A: newline, no write.
  - 0x08 with col>0: col-1, write 0x20 at the new position.
  - 0x08 with col=0 and row>0: row-1, col=COLS-1, write 0x20 there.
  - 0x08 with row=0 and col=0: no write, no move.
  - Any other code: ignored, no write.
  - PUT lasts 1 cycle, then IDLE unless a scroll is required.
- Newline:
  - col=0.
  - If cur_row<ROWS-1: row+1.
  - Else (cursor on the last row): row stays ROWS-1, top_row <= (top_row+1) mod ROWS, enter SCROLL_CLR.
- SCROLL_CLR:
  - Writes 0x20 to the COLS cells of the physical row equal to the old top_row (the new bottom row), ascending column, one per cycle.
  - Then IDLE.
- Cursor and top_row outputs update in the same cycle as the corresponding write.
- Busy/overflow: key_valid while ready=0 pulses ovf for 1 cycle; the key is discarded and state is unchanged.
- Wrap: top_row wraps ROWS-1 -> 0. Physical address wraps across the last row correctly.
- Reset mid-operation (any state) aborts immediately: all registers return to reset values and INIT restarts from address 0.
- Backspace never moves above logical row 0. It does not un-scroll.

Test Plan:
- Release rst -> 2100 consecutive wr_en pulses, wr_data=0x20, wr_addr 0..2099 ascending; ready=1 the cycle after the last write.
- key_asc=0x41 in IDLE -> next cycle wr_en=1, wr_addr=0, wr_data=0x41; cur_col=1; ready back high 1 cycle later.
- 70 printable keys from (0,0) -> last write at addr 69; cursor (1,0). Then 0x08 -> write 0x20 at addr 69; cursor (0,69). 0x08 at (0,0) -> no wr_en, cursor unchanged.
- Cursor at row 29, top_row=0, key 0x0D -> top_row=1; 70 writes of 0x20 at addr 0..69; ready=0 during the clear; then 'B' -> write at addr 0 (phys row 0 = logical 29).
- After 30 scrolls, top_row wraps to 0; a write at logical (29,5) -> addr (29+0)*70+5 = 2035.
- key_valid during SCROLL_CLR -> ovf single pulse, no extra write. rst asserted mid-scroll -> outputs zero immediately; INIT restarts at addr 0.

Source files
------------

// File: rtl/text_term_ctrl.sv
// Terminal write controller: turns accepted ASCII codes into single-cell text RAM
// writes, tracks the cursor and scrolls through a circular top-row pointer.
module text_term_ctrl #(
    parameter int COLS   = 70,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [7:0]        key_asc,
    output logic              ready,
    output logic              ovf,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [4:0]        cur_row,
    output logic [6:0]        cur_col,
    output logic [4:0]        top_row
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_PUT,
        ST_SCROLL_CLR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS * COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [5:0]        ROWS_W    = 6'(ROWS);
    localparam logic [7:0]        BLANK     = 8'h20;

    // Valid/ready: a key is taken on a clock edge where key_valid=1 and ready=1;
    // key_valid with ready=0 is dropped and flagged on ovf for one cycle.

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              ovf_q, ovf_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [4:0]        cur_row_q, cur_row_d;
    logic [6:0]        cur_col_q, cur_col_d;
    logic [4:0]        top_row_q, top_row_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic [6:0]        clr_cnt_q, clr_cnt_d;
    logic [4:0]        clr_row_q, clr_row_d;
    logic              scroll_q, scroll_d;

    logic is_print;
    logic is_nl;
    logic is_bs;
    logic do_nl;
    logic accept;

    assign is_print = (key_asc >= 8'h20) && (key_asc <= 8'h7E);
    assign is_nl    = (key_asc == 8'h0D) || (key_asc == 8'h0A);
    assign is_bs    = (key_asc == 8'h08);
    assign accept   = key_valid && ready_q && (state_q == ST_IDLE);

    function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] phys);
        return ADDR_W'(phys) * ADDR_W'(COLS);
    endfunction

    // Logical-to-physical row: the sum is below 2*ROWS, so one subtract suffices.
    function automatic logic [4:0] phys_row(input logic [4:0] row, input logic [4:0] top);
        logic [5:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum >= ROWS_W) begin
            sum = sum - ROWS_W;
        end
        return sum[4:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row,
                                                    input logic [4:0] top,
                                                    input logic [6:0] col);
        return row_base(phys_row(row, top)) + ADDR_W'(col);
    endfunction

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        ovf_d      = key_valid && !accept;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        top_row_d  = top_row_q;
        init_cnt_d = init_cnt_q;
        clr_cnt_d  = clr_cnt_q;
        clr_row_d  = clr_row_q;
        scroll_d   = scroll_q;
        do_nl      = 1'b0;

        case (state_q)
            ST_INIT: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = init_cnt_q;
                wr_data_d  = BLANK;
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                if (init_cnt_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d  = 1'b0;
                    state_d  = ST_PUT;
                    scroll_d = 1'b0;
                    // The cell write is decoded here so it lands in the PUT cycle.
                    if (is_print) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cell_addr(cur_row_q, top_row_q, cur_col_q);
                        wr_data_d = key_asc;
                        if (cur_col_q < LAST_COL) begin
                            cur_col_d = cur_col_q + 7'd1;
                        end else begin
                            do_nl = 1'b1;
                        end
                    end else if (is_nl) begin
                        do_nl = 1'b1;
                    end else if (is_bs) begin
                        if (cur_col_q != 7'd0) begin
                            cur_col_d = cur_col_q - 7'd1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = cell_addr(cur_row_q, top_row_q, cur_col_q - 7'd1);
                            wr_data_d = BLANK;
                        end else if (cur_row_q != 5'd0) begin
                            cur_row_d = cur_row_q - 5'd1;
                            cur_col_d = LAST_COL;
                            wr_en_d   = 1'b1;
                            wr_addr_d = cell_addr(cur_row_q - 5'd1, top_row_q, LAST_COL);
                            wr_data_d = BLANK;
                        end
                    end

                    if (do_nl) begin
                        cur_col_d = 7'd0;
                        if (cur_row_q < LAST_ROW) begin
                            cur_row_d = cur_row_q + 5'd1;
                        end else begin
                            // The old top row becomes the new bottom row and must be blanked.
                            top_row_d = (top_row_q == LAST_ROW) ? 5'd0 : top_row_q + 5'd1;
                            clr_row_d = top_row_q;
                            scroll_d  = 1'b1;
                        end
                    end
                end
            end

            ST_PUT: begin
                if (scroll_q) begin
                    state_d   = ST_SCROLL_CLR;
                    clr_cnt_d = 7'd0;
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end

            ST_SCROLL_CLR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = row_base(clr_row_q) + ADDR_W'(clr_cnt_q);
                wr_data_d = BLANK;
                clr_cnt_d = clr_cnt_q + 7'd1;
                if (clr_cnt_q == LAST_COL) begin
                    state_d  = ST_IDLE;
                    scroll_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            cur_row_q  <= 5'd0;
            cur_col_q  <= 7'd0;
            top_row_q  <= 5'd0;
            init_cnt_q <= '0;
            clr_cnt_q  <= 7'd0;
            clr_row_q  <= 5'd0;
            scroll_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            top_row_q  <= top_row_d;
            init_cnt_q <= init_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_row_q  <= clr_row_d;
            scroll_q   <= scroll_d;
        end
    end

    assign ready   = ready_q;
    assign ovf     = ovf_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cur_row = cur_row_q;
    assign cur_col = cur_col_q;
    assign top_row = top_row_q;

endmodule

// File: tb/tb_text_term_ctrl.sv
// Bench for text_term_ctrl: directed vector table, hand sequences for scroll,
// overflow and mid-scroll reset, then random keys against a screen-level model.
module tb_text_term_ctrl;

  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst;
  logic              key_valid;
  logic [7:0]        key_asc;
  logic              ready;
  logic              ovf;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [4:0]        cur_row;
  logic [6:0]        cur_col;
  logic [4:0]        top_row;

  text_term_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_asc   (key_asc),
    .ready     (ready),
    .ovf       (ovf),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .top_row   (top_row)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_bad = 0;

  // scoreboard: {addr, data} of every write seen vs. predicted
  logic [19:0] got_q[$];
  logic [19:0] exp_q[$];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_q.push_back({wr_addr, wr_data});
      if (ready === 1'b1) ready_bad++;
    end
  end

  // reference model: logical cursor plus top-row offset
  int m_row, m_col, m_top;

  task automatic m_write(input int r, input int c, input logic [7:0] d);
    int addr;
    addr = ((r + m_top) % ROWS) * COLS + c;
    exp_q.push_back({12'(addr), d});
  endtask

  task automatic m_newline();
    int old_top;
    m_col = 0;
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      old_top = m_top;
      m_top = (m_top + 1) % ROWS;
      for (int c = 0; c < COLS; c++) exp_q.push_back({12'(old_top * COLS + c), 8'h20});
    end
  endtask

  task automatic model_key(input logic [7:0] k);
    if (k >= 8'h20 && k <= 8'h7E) begin
      m_write(m_row, m_col, k);
      if (m_col < COLS - 1) m_col++;
      else m_newline();
    end else if (k == 8'h0D || k == 8'h0A) begin
      m_newline();
    end else if (k == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_write(m_row, m_col, 8'h20);
      end else if (m_row > 0) begin
        m_row--;
        m_col = COLS - 1;
        m_write(m_row, m_col, 8'h20);
      end
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // driver tasks
  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=%0b want=1", ready);
    end
  endtask

  task automatic press(input logic [7:0] k);
    wait_ready();
    key_asc   = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    model_key(k);
    wait_ready();
  endtask

  task automatic check_writes(input string tag);
    logic [19:0] g, e;
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_wr"}, int'(g), int'(e));
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_row"}, int'(cur_row), m_row);
    check({tag, "_col"}, int'(cur_col), m_col);
    check({tag, "_top"}, int'(top_row), m_top);
  endtask

  task automatic init_check(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      @(negedge clk);
      if (!(wr_en === 1'b1 && int'(wr_addr) == i && wr_data === 8'h20)) bad++;
    end
    check({tag, "_seq_bad"}, bad, 0);
    @(negedge clk);
    check({tag, "_ready"}, int'(ready), 1);
    check({tag, "_wr_off"}, int'(wr_en), 0);
    got_q.delete();
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    m_top = 0;
  endtask

  typedef struct {
    logic [7:0] key;
    logic       wr;
    int         addr;
    logic [7:0] data;
    int         row;
    int         col;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k;
    int r;

    // cursor starts at (0,1) after the latency test writes 'A'
    vecs[0]  = '{8'h42, 1'b1, 1,   8'h42, 0, 2};
    vecs[1]  = '{8'h08, 1'b1, 1,   8'h20, 0, 1};
    vecs[2]  = '{8'h08, 1'b1, 0,   8'h20, 0, 0};
    vecs[3]  = '{8'h08, 1'b0, 0,   8'h00, 0, 0};
    vecs[4]  = '{8'h01, 1'b0, 0,   8'h00, 0, 0};
    vecs[5]  = '{8'h0D, 1'b0, 0,   8'h00, 1, 0};
    vecs[6]  = '{8'h08, 1'b1, 69,  8'h20, 0, 69};
    vecs[7]  = '{8'h5A, 1'b1, 69,  8'h5A, 1, 0};
    vecs[8]  = '{8'h0A, 1'b0, 0,   8'h00, 2, 0};
    vecs[9]  = '{8'h7E, 1'b1, 140, 8'h7E, 2, 1};
    vecs[10] = '{8'h7F, 1'b0, 0,   8'h00, 2, 1};
    vecs[11] = '{8'h1F, 1'b0, 0,   8'h00, 2, 1};
    vecs[12] = '{8'h20, 1'b1, 141, 8'h20, 2, 2};

    rst = 1'b1;
    key_valid = 1'b0;
    key_asc = 8'h00;
    m_row = 0;
    m_col = 0;
    m_top = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_cursor", int'({cur_row, cur_col}), 0);
    check("rst_top", int'(top_row), 0);
    rst = 1'b0;
    init_check("init");

    // single-key latency
    key_asc = 8'h41;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("lat_wr_en", int'(wr_en), 1);
    check("lat_addr", int'(wr_addr), 0);
    check("lat_data", int'(wr_data), 8'h41);
    check("lat_col", int'(cur_col), 1);
    check("lat_ready_low", int'(ready), 0);
    @(negedge clk);
    check("lat_ready_back", int'(ready), 1);
    model_key(8'h41);
    check_writes("lat");

    for (int i = 0; i < 13; i++) begin
      press(vecs[i].key);
      check($sformatf("vec%0d_nwr", i), got_q.size(), vecs[i].wr ? 1 : 0);
      if (vecs[i].wr && got_q.size() > 0) begin
        check($sformatf("vec%0d_addr", i), int'(got_q[0][19:8]), vecs[i].addr);
        check($sformatf("vec%0d_data", i), int'(got_q[0][7:0]), int'(vecs[i].data));
      end
      check($sformatf("vec%0d_row", i), int'(cur_row), vecs[i].row);
      check($sformatf("vec%0d_col", i), int'(cur_col), vecs[i].col);
      check_writes($sformatf("vec%0d_m", i));
    end

    while (m_row < ROWS - 1) begin
      press(8'h0D);
      check_writes("to_bottom");
    end

    // first scroll, with a dropped key in the middle of the clear
    wait_ready();
    key_asc = 8'h0D;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    model_key(8'h0D);
    check("scroll_top", int'(top_row), 1);
    repeat (5) @(negedge clk);
    check("clr_ready_low", int'(ready), 0);
    key_asc = 8'h51;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("ovf_pulse", int'(ovf), 1);
    @(negedge clk);
    check("ovf_single", int'(ovf), 0);
    wait_ready();
    check_writes("scroll");

    press(8'h42);
    check("b_addr", got_q.size() > 0 ? int'(got_q[0][19:8]) : -1, 0);
    check_writes("b_after_scroll");

    repeat (ROWS - 1) begin
      press(8'h0D);
      check_writes("wrap_scroll");
    end
    check("wrap_top", int'(top_row), 0);
    repeat (5) press(8'h78);
    check_writes("wrap_fill");
    press(8'h57);
    check("wrap_addr", got_q.size() > 0 ? int'(got_q[0][19:8]) : -1, 2035);
    check_writes("wrap_w");

    // reset in the middle of a scroll clear
    wait_ready();
    key_asc = 8'h0D;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_clr_active", int'(wr_en), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en", int'(wr_en), 0);
    check("mid_rst_addr", int'(wr_addr), 0);
    check("mid_rst_data", int'(wr_data), 0);
    check("mid_rst_ready", int'(ready), 0);
    check("mid_rst_cursor", int'({cur_row, cur_col}), 0);
    check("mid_rst_top", int'(top_row), 0);
    @(negedge clk);
    rst = 1'b0;
    init_check("reinit");

    // a full row of printable keys, then backspace across the row boundary
    repeat (COLS) press(8'($urandom_range(32, 126)));
    check("row_nwr", got_q.size(), COLS);
    check("row_last_addr", got_q.size() == COLS ? int'(got_q[COLS-1][19:8]) : -1, 69);
    check_writes("row_fill");
    check("row_cursor", int'({cur_row, cur_col}), int'({5'd1, 7'd0}));
    press(8'h08);
    check("bs_back_addr", got_q.size() > 0 ? int'(got_q[0][19:8]) : -1, 69);
    check_writes("bs_back");
    check("bs_cursor", int'({cur_row, cur_col}), int'({5'd0, 7'd69}));

    // random keys
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) k = 8'($urandom_range(32, 126));
      else if (r == 6) k = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
      else if (r <= 8) k = 8'h08;
      else k = 8'($urandom_range(128, 255));
      press(k);
      check_writes("rand");
    end

    check("ready_during_write", ready_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
